// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the fifo_sync read-side stream drain.
// Occupancy encodings are fixed values that other fifo_sync users already rely on.
package fifo_stream_reader_pkg;

    localparam int unsigned FIFO_RD_LATENCY    = 1;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_PKT_LEN    = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    // Words that will be buffered once the in-flight read lands and this cycle's pop retires.
    function automatic logic [2:0] occ_level(input occ_t occ, input logic inflight,
                                             input logic pop);
        return 3'(occ) + 3'(inflight) - 3'(pop);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry head/tail output buffer that absorbs the FIFO read latency.
// head_data is the registered stream data; tail holds the second word when occ is TWO.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] tail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            occ       <= OCC_EMPTY;
            head_data <= '0;
            tail_q    <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head_data <= push_data;
                        occ       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q <= push_data;
                            occ    <= OCC_TWO;
                        end
                        2'b11:   head_data <= push_data;
                        2'b01:   occ       <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    // Head advances from tail; a simultaneous push refills the vacated tail slot.
                    if (pop) begin
                        head_data <= tail_q;
                        if (push) tail_q <= push_data;
                        else      occ    <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !pop && occ == OCC_TWO))
                else $error("stream_skid_buf: push into full buffer");
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains fifo_sync into a valid/ready stream with m_last every PKT_LEN beats.
// Read issue looks ahead at this cycle's pop so a ready sink sees one beat per cycle.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned PKT_LEN    = DEFAULT_PKT_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int unsigned           CNT_W    = $clog2(PKT_LEN) + 1;
    localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(PKT_LEN - 1);

    occ_t             occ;
    logic             inflight;
    logic             pop;
    logic [CNT_W-1:0] beat_cnt;

    assign m_valid    = (occ != OCC_EMPTY);
    assign pop        = m_valid && m_ready;
    assign fifo_rd_en = !rst && !fifo_empty && (occ_level(occ, inflight, pop) < 3'd2);
    assign m_last     = m_valid && (beat_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop) begin
                if (beat_cnt == LAST_IDX) beat_cnt <= '0;
                else                      beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(fifo_data),
        .pop      (pop),
        .occ      (occ),
        .head_data(m_data)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader against a behavioural 1-cycle-latency FIFO.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned PL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    logic [DW-1:0] mem [0:255];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [DW-1:0] beat_data [$];
    logic          beat_last [$];
    int unsigned   beat_cyc  [$];
    int unsigned   cyc = 0, issued = 0, accepted = 0, max_out = 0, stab_err = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            beat_data.delete();
            beat_last.delete();
            beat_cyc.delete();
            issued     = 0;
            accepted   = 0;
            max_out    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stab_err++;
            if (fifo_rd_en) issued++;
            if (m_valid && m_ready) begin
                beat_data.push_back(m_data);
                beat_last.push_back(m_last);
                beat_cyc.push_back(cyc);
                accepted++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
            else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic fifo_flush();
        wr_ptr = rd_ptr;
    endtask

    task automatic fifo_push(input logic [DW-1:0] d);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
    endtask

    task automatic wait_beats(input int unsigned n, input int unsigned budget, input string tag);
        int unsigned k = 0;
        while (beat_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(beat_data.size() >= n), 32'd1);
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        fifo_flush();
    endtask

    initial begin
        logic [DW-1:0] exp_head;

        // Reset held with a non-empty FIFO
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifo_push(DW'(i));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_valid", 32'(m_valid), 32'd0);
            check("rst_last", 32'(m_last), 32'd0);
        end
        check("rst_data", m_data, 32'd0);

        // Full-rate streaming of 0..15
        rst = 1'b0;
        #1;
        check("first_rd_en", 32'(fifo_rd_en), 32'd1);
        check("lat_valid_c0", 32'(m_valid), 32'd0);
        tick();
        check("lat_valid_c1", 32'(m_valid), 32'd0);
        tick();
        check("lat_valid_c2", 32'(m_valid), 32'd1);
        check("lat_data_c2", m_data, 32'd0);
        wait_beats(16, 100, "stream_timeout");
        for (int i = 0; i < 16; i++) begin
            check("stream_data", beat_data[i], 32'(i));
            check("stream_last", 32'(beat_last[i]), 32'(i % 8 == 7));
            check("stream_b2b", beat_cyc[i] - beat_cyc[0], 32'(i));
        end
        check("stream_max_out", 32'(max_out <= 2), 32'd1);

        // Back-pressure mid-stream
        do_reset(2);
        for (int i = 0; i < 20; i++) fifo_push(DW'(100 + i));
        rst     = 1'b0;
        m_ready = 1'b1;
        wait_beats(4, 50, "bp_start_timeout");
        m_ready  = 1'b0;
        exp_head = DW'(100 + beat_data.size());
        repeat (5) tick();
        check("bp_occ_two", 32'(dut.occ), 32'(OCC_TWO));
        check("bp_rd_en", 32'(fifo_rd_en), 32'd0);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data_held", m_data, exp_head);
        m_ready = 1'b1;
        wait_beats(20, 100, "bp_timeout");
        for (int i = 0; i < 20; i++) check("bp_order", beat_data[i], 32'(100 + i));
        check("bp_max_out", 32'(max_out <= 2), 32'd1);

        // Alternating ready
        do_reset(2);
        for (int i = 0; i < 10; i++) fifo_push(DW'(200 + i));
        rst = 1'b0;
        begin
            int unsigned k = 0;
            while (beat_data.size() < 10 && k < 100) begin
                m_ready = (k % 2 == 0);
                tick();
                k++;
            end
        end
        check("alt_count", 32'(beat_data.size() >= 10), 32'd1);
        for (int i = 0; i < 10; i++) check("alt_order", beat_data[i], 32'(200 + i));
        check("alt_max_out", 32'(max_out <= 2), 32'd1);

        // Single-word drain
        do_reset(2);
        fifo_push(32'hAB);
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (10) tick();
        check("drain_beats", 32'(beat_data.size()), 32'd1);
        check("drain_data", beat_data[0], 32'hAB);
        check("drain_last", 32'(beat_last[0]), 32'd0);
        check("drain_reads", issued, 32'd1);
        check("drain_valid", 32'(m_valid), 32'd0);

        // Reset mid-packet with a full buffer, then refill
        do_reset(2);
        for (int i = 0; i < 20; i++) fifo_push(DW'(300 + i));
        rst     = 1'b0;
        m_ready = 1'b1;
        wait_beats(3, 50, "mid_start_timeout");
        m_ready = 1'b0;
        repeat (3) tick();
        check("mid_occ_two", 32'(dut.occ), 32'(OCC_TWO));
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_last", 32'(m_last), 32'd0);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        tick();
        fifo_flush();
        for (int i = 0; i < 8; i++) fifo_push(DW'(400 + i));
        rst     = 1'b0;
        m_ready = 1'b1;
        wait_beats(8, 50, "refill_timeout");
        for (int i = 0; i < 8; i++) begin
            check("refill_data", beat_data[i], 32'(400 + i));
            check("refill_last", 32'(beat_last[i]), 32'(i == 7));
        end

        check("hold_stable", stab_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
